// File: rtl/block_serializer_if.sv
// block_serializer_if
// Groups the block-input handshake and the serial bit-stream handshake of the
// JPEG block serializer.
//   table_value : 64 x 8-bit coefficients, raster index k at [8k+7:8k]
//   s_valid     : table_value valid (producer -> serializer)
//   s_ready     : serializer can accept a block
//   bit_out     : current stream bit
//   bit_valid   : bit_out valid
//   bit_ready   : sink accepts the current bit
// Modports: master = block producer / bit sink side, slave = serializer side.
interface block_serializer_if #(
   parameter int TABLE_SIZE  = 64,
   parameter int COEFF_WIDTH = 8
);
   logic [TABLE_SIZE*COEFF_WIDTH-1:0] table_value;
   logic                              s_valid;
   logic                              s_ready;
   logic                              bit_out;
   logic                              bit_valid;
   logic                              bit_ready;

   modport master (
      output table_value,
      output s_valid,
      input  s_ready,
      input  bit_out,
      input  bit_valid,
      output bit_ready
   );

   modport slave (
      input  table_value,
      input  s_valid,
      output s_ready,
      output bit_out,
      output bit_valid,
      input  bit_ready
   );
endinterface

// File: rtl/block_serializer.sv
// block_serializer
// Takes one 8x8 block of quantized coefficients, walks it in JPEG zigzag
// order, run-length codes the zero runs and streams (run, coefficient)
// symbols out one bit per handshake: 4-bit run then 8-bit coefficient, MSB
// first. Every block ends with an EOB symbol (0,0); 16-zero runs become ZRL
// symbols (15,0).
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   bus        : block_serializer_if.slave (block input + bit stream)
//   block_done : one-cycle pulse after the last EOB bit is accepted
//   busy       : a block is in progress
module block_serializer #(
   parameter int TABLE_SIZE  = 64,
   parameter int COEFF_WIDTH = 8,
   parameter int RUN_WIDTH   = 4
) (
   input  logic                clk,
   input  logic                rst,
   block_serializer_if.slave   bus,
   output logic                block_done,
   output logic                busy
);

   localparam int SYM_WIDTH = RUN_WIDTH + COEFF_WIDTH;

   // Raster index of each zigzag position.
   localparam int ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
   };

   typedef enum logic [1:0] {IDLE, LOAD, SCAN, EMIT} state_t;

   state_t                              state;
   state_t                              state_next;

   logic [TABLE_SIZE*COEFF_WIDTH-1:0]   table_q;
   logic [COEFF_WIDTH-1:0]              zz_q [TABLE_SIZE];
   logic [TABLE_SIZE-1:0]               nz_mask;
   logic [5:0]                          last_nz_c;
   logic                                any_nz_q;
   logic [5:0]                          last_nz_q;
   logic [6:0]                          idx_q;
   logic [RUN_WIDTH-1:0]                run_q;
   logic [SYM_WIDTH-1:0]                shreg_q;
   logic [3:0]                          bit_cnt_q;
   logic                                eob_q;
   logic                                done_q;
   logic                                ready_q;

   logic                                accept_in;
   logic                                bit_take;
   logic                                sym_end;
   logic [COEFF_WIDTH-1:0]              coef_c;
   logic                                scan_eob;
   logic                                scan_emit;

   assign accept_in = (state == IDLE) && ready_q && bus.s_valid;
   assign bit_take  = (state == EMIT) && bus.bit_ready;
   assign sym_end   = bit_take && (bit_cnt_q == 4'd11);
   // idx_q can reach 64; scan_eob covers that case before coef_c is used.
   assign coef_c    = zz_q[idx_q[5:0]];
   assign scan_eob  = !any_nz_q || (idx_q > {1'b0, last_nz_q});
   assign scan_emit = scan_eob || (coef_c != '0) || (run_q == '1);

   // Nonzero mask in zigzag order and the highest nonzero zigzag position,
   // both derived from the latched raster table during LOAD.
   always_comb begin
      nz_mask   = '0;
      last_nz_c = '0;
      for (int k = 0; k < TABLE_SIZE; k++) begin
         nz_mask[k] = |table_q[ZZ[k]*COEFF_WIDTH +: COEFF_WIDTH];
         if (nz_mask[k]) begin
            last_nz_c = 6'(k);
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and handshake outputs. All outputs come straight from
   // registers or the state register, so they are glitch-free and hold while
   // the sink stalls.
   always_comb begin
      state_next    = state;
      bus.s_ready   = ready_q;
      bus.bit_out   = shreg_q[SYM_WIDTH-1];
      bus.bit_valid = (state == EMIT);
      busy          = (state != IDLE);
      block_done    = done_q;
      case (state)
         IDLE: if (accept_in) state_next = LOAD;
         LOAD: state_next = SCAN;
         SCAN: if (scan_emit) state_next = EMIT;
         EMIT: if (sym_end) state_next = eob_q ? IDLE : SCAN;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: block latch, zigzag reorder, run counting and the symbol
   // shift register. s_ready is registered from the next state so it is low
   // throughout reset and rises on the first clock after release, and again
   // in the same cycle as block_done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         table_q   <= '0;
         for (int k = 0; k < TABLE_SIZE; k++) zz_q[k] <= '0;
         any_nz_q  <= 1'b0;
         last_nz_q <= '0;
         idx_q     <= '0;
         run_q     <= '0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         eob_q     <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         ready_q <= (state_next == IDLE);
         done_q  <= sym_end && eob_q;
         case (state)
            IDLE: begin
               if (accept_in) begin
                  table_q <= bus.table_value;
                  run_q   <= '0;
                  idx_q   <= '0;
                  eob_q   <= 1'b0;
               end
            end
            LOAD: begin
               for (int k = 0; k < TABLE_SIZE; k++) begin
                  zz_q[k] <= table_q[ZZ[k]*COEFF_WIDTH +: COEFF_WIDTH];
               end
               any_nz_q  <= |nz_mask;
               last_nz_q <= last_nz_c;
            end
            SCAN: begin
               bit_cnt_q <= '0;
               if (scan_eob) begin
                  shreg_q <= '0;
                  eob_q   <= 1'b1;
               end else if (coef_c != '0) begin
                  shreg_q <= {run_q, coef_c};
                  run_q   <= '0;
               end else if (run_q == '1) begin
                  // ZRL: the current zero is the 16th of the run.
                  shreg_q <= {{RUN_WIDTH{1'b1}}, {COEFF_WIDTH{1'b0}}};
                  run_q   <= '0;
               end else begin
                  run_q <= run_q + 1'b1;
                  idx_q <= idx_q + 7'd1;
               end
            end
            EMIT: begin
               if (bit_take) begin
                  shreg_q   <= {shreg_q[SYM_WIDTH-2:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (sym_end && !eob_q) begin
                     idx_q <= idx_q + 7'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_block_serializer.sv
// tb_block_serializer
// Self-checking bench for block_serializer. Expected bit streams come from a
// behavioural model that walks the zigzag diagonals and run-length codes the
// block with plain arithmetic.
module tb_block_serializer;

   logic clk;
   logic rst;
   logic block_done;
   logic busy;

   block_serializer_if bus ();

   block_serializer dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .block_done (block_done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_count  = 0;
   int check_count = 0;

   bit got_bits[$];
   bit exp_bits[$];
   int zz_raster[64];

   int done_count;
   int first_valid;
   int stable_err;
   int sready_err;
   int timed_out;
   bit ready_at_done;
   bit chain_busy;
   bit chain_sready;

   // Zigzag order built by walking the anti-diagonals of the 8x8 block.
   function automatic void build_zigzag();
      int n;
      int lo;
      int hi;
      n = 0;
      for (int s = 0; s < 15; s++) begin
         lo = (s > 7) ? s - 7 : 0;
         hi = (s < 8) ? s : 7;
         if (s % 2 == 0) begin
            for (int r = hi; r >= lo; r--) begin
               zz_raster[n] = r * 8 + (s - r);
               n++;
            end
         end else begin
            for (int r = lo; r <= hi; r++) begin
               zz_raster[n] = r * 8 + (s - r);
               n++;
            end
         end
      end
   endfunction

   function automatic void push_sym(input int run, input logic [7:0] c);
      logic [3:0] r4;
      r4 = 4'(run);
      for (int b = 3; b >= 0; b--) exp_bits.push_back(r4[b]);
      for (int b = 7; b >= 0; b--) exp_bits.push_back(c[b]);
   endfunction

   // Reference model: nonzeros up to the last one, zero runs split into
   // 16-zero chunks, then an EOB.
   function automatic void build_expected(input logic [511:0] blk);
      int last;
      int zeros;
      logic [7:0] c;
      exp_bits.delete();
      last = -1;
      for (int p = 0; p < 64; p++) begin
         if (blk[zz_raster[p]*8 +: 8] != 8'h00) last = p;
      end
      zeros = 0;
      for (int p = 0; p <= last; p++) begin
         c = blk[zz_raster[p]*8 +: 8];
         if (c == 8'h00) begin
            zeros++;
         end else begin
            while (zeros >= 16) begin
               push_sym(15, 8'h00);
               zeros -= 16;
            end
            push_sym(zeros, c);
            zeros = 0;
         end
      end
      push_sym(0, 8'h00);
   endfunction

   function automatic int bit_diffs();
      int n;
      int d;
      n = (got_bits.size() > exp_bits.size()) ? got_bits.size() : exp_bits.size();
      d = 0;
      for (int i = 0; i < n; i++) begin
         if (i >= got_bits.size() || i >= exp_bits.size()) d++;
         else if (got_bits[i] !== exp_bits[i]) d++;
      end
      return d;
   endfunction

   function automatic logic [511:0] random_block(input int density);
      logic [511:0] blk;
      blk = '0;
      for (int k = 0; k < 64; k++) begin
         if ($urandom_range(0, density) == 0) blk[k*8 +: 8] = 8'($urandom);
      end
      return blk;
   endfunction

   // Hands one block to the DUT (unless skip_hs: already accepted) and
   // collects the bit stream until block_done, recording handshake
   // observations. stop_after >= 0 returns early once that many bits are in.
   task automatic applyStimulus(input logic [511:0] blk, input bit rand_ready,
                                input bit poke, input int stop_after,
                                input bit chain, input bit skip_hs);
      int n;
      int cyc;
      bit prev_hold;
      bit prev_bit;
      got_bits.delete();
      done_count    = 0;
      first_valid   = -1;
      stable_err    = 0;
      sready_err    = 0;
      timed_out     = 0;
      ready_at_done = 1'b0;
      chain_busy    = 1'b0;
      chain_sready  = 1'b0;
      if (!skip_hs) begin
         @(negedge clk);
         n = 0;
         while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!bus.s_ready) begin
            timed_out = 1;
            return;
         end
         bus.table_value = blk;
         bus.s_valid     = 1'b1;
         bus.bit_ready   = 1'b1;
         @(negedge clk);
         bus.s_valid = 1'b0;
      end
      prev_hold = 1'b0;
      prev_bit  = 1'b0;
      for (cyc = 1; cyc < 3000; cyc++) begin
         if (bus.bit_valid && first_valid < 0) first_valid = cyc;
         if (prev_hold && (!bus.bit_valid || bus.bit_out !== prev_bit)) stable_err++;
         if (block_done) begin
            done_count++;
            ready_at_done = bus.s_ready;
            break;
         end
         if (bus.s_ready) sready_err++;
         if (stop_after >= 0 && got_bits.size() == stop_after) return;
         bus.bit_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (poke) begin
            bus.s_valid     = ($urandom_range(0, 3) == 0);
            bus.table_value = random_block(2);
         end
         if (bus.bit_valid && bus.bit_ready) got_bits.push_back(bus.bit_out);
         prev_hold = bus.bit_valid && !bus.bit_ready;
         prev_bit  = bus.bit_out;
         @(negedge clk);
      end
      if (done_count == 0) begin
         timed_out     = 1;
         bus.s_valid   = 1'b0;
         return;
      end
      if (chain) begin
         bus.table_value = '0;
         bus.s_valid     = 1'b1;
         bus.bit_ready   = 1'b1;
         @(negedge clk);
         bus.s_valid  = 1'b0;
         chain_busy   = busy;
         chain_sready = bus.s_ready;
         return;
      end
      bus.s_valid   = 1'b0;
      bus.bit_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (block_done) done_count++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.s_valid     = 1'b0;
      bus.bit_ready   = 1'b0;
      bus.table_value = '0;
      repeat (3) @(negedge clk);
      check_count++;
      if (bus.s_ready !== 1'b0) $display("[TB] FAIL reset_s_ready got=%b want=0", bus.s_ready);
      else pass_count++;
      check_count++;
      if (bus.bit_valid !== 1'b0) $display("[TB] FAIL reset_bit_valid got=%b want=0", bus.bit_valid);
      else pass_count++;
      check_count++;
      if (bus.bit_out !== 1'b0) $display("[TB] FAIL reset_bit_out got=%b want=0", bus.bit_out);
      else pass_count++;
      check_count++;
      if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b want=0", busy);
      else pass_count++;
      check_count++;
      if (block_done !== 1'b0) $display("[TB] FAIL reset_block_done got=%b want=0", block_done);
      else pass_count++;
      rst = 1'b1;
      @(negedge clk);
      check_count++;
      if (bus.s_ready !== 1'b1) $display("[TB] FAIL post_reset_s_ready got=%b want=1", bus.s_ready);
      else pass_count++;
   endtask

   task automatic checkOutput(input string name, input int want_bits);
      check_count++;
      if (timed_out != 0) $display("[TB] FAIL %s_timeout got=%0d want=0", name, timed_out);
      else pass_count++;
      check_count++;
      if (got_bits.size() != want_bits)
         $display("[TB] FAIL %s_bit_count got=%0d want=%0d", name, got_bits.size(), want_bits);
      else pass_count++;
      check_count++;
      if (bit_diffs() != 0) $display("[TB] FAIL %s_bits got=%0d differing bits want=0", name, bit_diffs());
      else pass_count++;
      check_count++;
      if (done_count != 1) $display("[TB] FAIL %s_done_pulses got=%0d want=1", name, done_count);
      else pass_count++;
      check_count++;
      if (ready_at_done !== 1'b1) $display("[TB] FAIL %s_ready_at_done got=%b want=1", name, ready_at_done);
      else pass_count++;
   endtask

   task automatic test_all_zero();
      build_expected('0);
      applyStimulus('0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      checkOutput("all_zero", 12);
      check_count++;
      if (first_valid != 3) $display("[TB] FAIL all_zero_latency got=%0d want=3", first_valid);
      else pass_count++;
   endtask

   task automatic test_dc_only();
      logic [511:0] blk;
      blk = '0;
      blk[7:0] = 8'd5;
      build_expected(blk);
      applyStimulus(blk, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      checkOutput("dc_only", 24);
   endtask

   task automatic test_two_coeffs();
      logic [511:0] blk;
      blk = '0;
      blk[1*8 +: 8] = 8'h03;
      blk[8*8 +: 8] = 8'hFE;
      build_expected(blk);
      applyStimulus(blk, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      checkOutput("two_coeffs", 36);
   endtask

   task automatic test_zrl();
      logic [511:0] blk;
      blk = '0;
      blk[63*8 +: 8] = 8'hFF;
      build_expected(blk);
      applyStimulus(blk, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      checkOutput("zrl", 60);
   endtask

   task automatic test_random();
      logic [511:0] blk;
      int dens[4] = '{1, 4, 12, 40};
      for (int t = 0; t < 4; t++) begin
         blk = random_block(dens[t]);
         build_expected(blk);
         applyStimulus(blk, 1'b1, 1'b1, -1, 1'b0, 1'b0);
         checkOutput($sformatf("random%0d", t), exp_bits.size());
         check_count++;
         if (stable_err != 0) $display("[TB] FAIL random%0d_stall_stable got=%0d violations want=0", t, stable_err);
         else pass_count++;
         check_count++;
         if (sready_err != 0) $display("[TB] FAIL random%0d_s_ready_low got=%0d violations want=0", t, sready_err);
         else pass_count++;
      end
   endtask

   task automatic test_back_to_back();
      logic [511:0] blk;
      blk = '0;
      blk[1*8 +: 8] = 8'h03;
      blk[8*8 +: 8] = 8'hFE;
      applyStimulus(blk, 1'b0, 1'b0, -1, 1'b1, 1'b0);
      check_count++;
      if (chain_busy !== 1'b1 || chain_sready !== 1'b0)
         $display("[TB] FAIL b2b_accept got busy=%b s_ready=%b want busy=1 s_ready=0", chain_busy, chain_sready);
      else pass_count++;
      build_expected('0);
      applyStimulus('0, 1'b0, 1'b0, -1, 1'b0, 1'b1);
      checkOutput("b2b_second", 12);
      check_count++;
      if (first_valid != 3) $display("[TB] FAIL b2b_latency got=%0d want=3", first_valid);
      else pass_count++;
   endtask

   task automatic test_reset_mid_block();
      logic [511:0] blk;
      blk = '0;
      blk[1*8 +: 8] = 8'h03;
      blk[8*8 +: 8] = 8'hFE;
      applyStimulus(blk, 1'b0, 1'b0, 15, 1'b0, 1'b0);
      check_count++;
      if (bus.bit_valid !== 1'b1) $display("[TB] FAIL mid_emit_valid got=%b want=1", bus.bit_valid);
      else pass_count++;
      rst = 1'b0;
      #1;
      check_count++;
      if (bus.bit_valid !== 1'b0 || busy !== 1'b0)
         $display("[TB] FAIL mid_reset_outputs got bit_valid=%b busy=%b want 0 0", bus.bit_valid, busy);
      else pass_count++;
      check_count++;
      if (bus.s_ready !== 1'b0) $display("[TB] FAIL mid_reset_s_ready got=%b want=0", bus.s_ready);
      else pass_count++;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      build_expected('0);
      applyStimulus('0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      checkOutput("after_reset", 12);
   endtask

   initial begin
      build_zigzag();
      test_reset();
      test_all_zero();
      test_dc_only();
      test_two_coeffs();
      test_zrl();
      test_random();
      test_back_to_back();
      test_reset_mid_block();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
